// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited sequential fetches
// and buffers returned words in an in-order queue for decode.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        i_Clk_1,
   input  logic        i_Rst_1,
   input  logic        i_Redirect_1,
   input  logic [31:0] i_RedirectPC_32,
   output logic        o_IMemReq_1,
   output logic [31:0] o_IMemAddr_32,
   input  logic        i_IMemGnt_1,
   input  logic        i_IMemRValid_1,
   input  logic [31:0] i_IMemRData_32,
   output logic        o_InstValid_1,
   output logic [31:0] o_Inst_32,
   output logic [31:0] o_InstPC_32,
   input  logic        i_DecodeReady_1
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam logic [CW-1:0] DEPTH_CW = CW'(QUEUE_DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t        q   [QUEUE_DEPTH];
   logic [31:0]   tag [QUEUE_DEPTH];
   logic [PW-1:0] q_head, q_tail, t_head, t_tail;
   logic [CW-1:0] occ, out_cnt, disc, out_next;
   logic [31:0]   pc, redirect_pc;
   logic          grant, push, pop, drop, inst_valid;

   always_comb begin
      o_IMemReq_1 = !i_Rst_1 && (({1'b0, out_cnt} + {1'b0, occ}) < {1'b0, DEPTH_CW});
      grant       = o_IMemReq_1 && i_IMemGnt_1;
      drop        = i_IMemRValid_1 && (disc != '0);
      // a response arriving alongside a redirect belongs to the old stream
      push        = i_IMemRValid_1 && (disc == '0) && !i_Redirect_1;
      inst_valid  = !i_Rst_1 && (occ != '0);
      pop         = inst_valid && i_DecodeReady_1;
      out_next    = out_cnt + CW'(grant) - CW'(i_IMemRValid_1);
      redirect_pc = i_RedirectPC_32 & ~32'd3;
   end

   assign o_IMemAddr_32 = pc;
   assign o_InstValid_1 = inst_valid;
   assign o_Inst_32     = inst_valid ? q[q_head].inst : '0;
   assign o_InstPC_32   = inst_valid ? q[q_head].pc   : '0;

   always_ff @(posedge i_Clk_1) begin
      if (i_Rst_1) begin
         pc      <= RESET_PC;
         occ     <= '0;
         out_cnt <= '0;
         disc    <= '0;
         q_head  <= '0;
         q_tail  <= '0;
         t_head  <= '0;
         t_tail  <= '0;
      end else begin
         out_cnt <= out_next;
         // tag FIFO tracks every request, including ones that will be discarded
         if (grant)          t_tail <= t_tail + PW'(1);
         if (i_IMemRValid_1) t_head <= t_head + PW'(1);
         if (i_Redirect_1) begin
            pc     <= redirect_pc;
            occ    <= '0;
            q_head <= '0;
            q_tail <= '0;
            disc   <= out_next;
         end else begin
            if (grant) pc     <= pc + 32'd4;
            if (drop)  disc   <= disc - CW'(1);
            if (push)  q_tail <= q_tail + PW'(1);
            if (pop)   q_head <= q_head + PW'(1);
            occ <= occ + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge i_Clk_1) begin
      if (grant) tag[t_tail] <= pc;
      if (push)  q[q_tail]   <= '{inst: i_IMemRData_32, pc: tag[t_head]};
   end

   always_ff @(posedge i_Clk_1) begin
      if (!i_Rst_1) begin
         assert (!(i_IMemRValid_1 && (out_cnt == '0)));
         assert (occ <= DEPTH_CW);
      end
   end

endmodule
